// File: rtl/slot_allocator.sv
// Slot allocator: tracks occupancy of NUM_SLOT slots, grants the lowest free slot
// combinationally and accepts slot releases, with a sticky flag for bad releases.

module find_first_one_index #(
   parameter int unsigned VECTOR_LENGTH    = 8,
   parameter int unsigned MAX_OUTPUT_WIDTH = 32
) (
   input  logic [VECTOR_LENGTH-1:0]    vector_in,
   output logic [MAX_OUTPUT_WIDTH-1:0] first_one_index_out,
   output logic                        one_is_found_out
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      first_one_index_out = '0;
      for (int i = VECTOR_LENGTH - 1; i >= 0; i--) begin
         if (vector_in[i]) begin
            first_one_index_out = MAX_OUTPUT_WIDTH'(i);
         end
      end
   end

   assign one_is_found_out = |vector_in;

endmodule

module slot_allocator #(
   parameter int unsigned NUM_SLOT      = 8,
   parameter int unsigned NUM_SLOT_LOG2 = 3
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic                     alloc_request_in,
   output logic                     alloc_grant_out,
   output logic [NUM_SLOT_LOG2-1:0] alloc_index_out,
   input  logic                     release_valid_in,
   input  logic [NUM_SLOT_LOG2-1:0] release_index_in,
   output logic [NUM_SLOT-1:0]      busy_vector_out,
   output logic [NUM_SLOT_LOG2:0]   busy_count_out,
   output logic                     full_out,
   output logic                     empty_out,
   output logic                     error_out
);

   localparam logic [NUM_SLOT_LOG2:0] FULL_COUNT = (NUM_SLOT_LOG2 + 1)'(NUM_SLOT);
   localparam logic [NUM_SLOT_LOG2:0] COUNT_ONE  = (NUM_SLOT_LOG2 + 1)'(1);

   logic [NUM_SLOT-1:0]      r_busy;
   logic [NUM_SLOT_LOG2:0]   r_count;
   logic                     r_full;
   logic                     r_empty;
   logic                     r_error;

   logic [NUM_SLOT-1:0]      w_free;
   logic [31:0]              w_cand_full;
   logic                     w_cand_found;
   logic [NUM_SLOT_LOG2-1:0] w_cand;
   logic                     w_grant;
   logic                     w_rel_in_range;
   logic                     w_rel_hit;
   logic                     w_rel_bad;
   logic [NUM_SLOT-1:0]      w_set_mask;
   logic [NUM_SLOT-1:0]      w_clr_mask;
   logic [NUM_SLOT-1:0]      w_busy_next;
   logic [NUM_SLOT_LOG2:0]   w_count_next;
   logic                     w_unused_cand;

   assign w_free = ~r_busy;

   find_first_one_index #(
      .VECTOR_LENGTH    (NUM_SLOT),
      .MAX_OUTPUT_WIDTH (32)
   ) u_find_free (
      .vector_in           (w_free),
      .first_one_index_out (w_cand_full),
      .one_is_found_out    (w_cand_found)
   );

   assign w_cand        = w_cand_full[NUM_SLOT_LOG2-1:0];
   assign w_unused_cand = ^{w_cand_full[31:NUM_SLOT_LOG2], w_cand_found};

   // Grant looks only at registered state, so a same-cycle release never frees a slot early.
   assign w_grant = alloc_request_in & ~r_full & ~reset_in;

   assign w_rel_in_range = (32'(release_index_in) < NUM_SLOT);
   assign w_rel_hit      = release_valid_in & w_rel_in_range & r_busy[release_index_in];
   assign w_rel_bad      = release_valid_in & ~w_rel_hit;

   always_comb begin
      w_set_mask   = '0;
      w_clr_mask   = '0;
      w_count_next = r_count;
      if (w_grant) begin
         w_set_mask[w_cand] = 1'b1;
      end
      if (w_rel_hit) begin
         w_clr_mask[release_index_in] = 1'b1;
      end
      w_busy_next = (r_busy | w_set_mask) & ~w_clr_mask;
      unique case ({w_grant, w_rel_hit})
         2'b10:   w_count_next = r_count + COUNT_ONE;
         2'b01:   w_count_next = r_count - COUNT_ONE;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_busy  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_error <= 1'b0;
      end else begin
         r_busy  <= w_busy_next;
         r_count <= w_count_next;
         r_full  <= (w_count_next == FULL_COUNT);
         r_empty <= (w_count_next == '0);
         r_error <= r_error | w_rel_bad;
      end
   end

   assign alloc_grant_out = w_grant;
   assign alloc_index_out = reset_in ? '0 : w_cand;
   assign busy_vector_out = r_busy;
   assign busy_count_out  = r_count;
   assign full_out        = r_full;
   assign empty_out       = r_empty;
   assign error_out       = r_error;

endmodule

// File: tb/tb_slot_allocator.sv
// Scoreboard bench for slot_allocator: a bitmap model queues expected grant and
// state values per cycle, which are popped and compared against the DUT outputs.

module tb_slot_allocator;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic       rel_v;
   logic [2:0] rel_idx;
   logic       grant;
   logic [2:0] idx;
   logic [7:0] busy;
   logic [3:0] cnt;
   logic       full;
   logic       empty;
   logic       err;

   slot_allocator #(
      .NUM_SLOT      (8),
      .NUM_SLOT_LOG2 (3)
   ) dut (
      .clk_in           (clk),
      .reset_in         (rst),
      .alloc_request_in (req),
      .alloc_grant_out  (grant),
      .alloc_index_out  (idx),
      .release_valid_in (rel_v),
      .release_index_in (rel_idx),
      .busy_vector_out  (busy),
      .busy_count_out   (cnt),
      .full_out         (full),
      .empty_out        (empty),
      .error_out        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       grant;
      logic [2:0] idx;
      logic       chk_idx;
   } comb_exp_t;

   typedef struct {
      logic [7:0] busy;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       err;
   } state_exp_t;

   comb_exp_t  q_comb[$];
   state_exp_t q_state[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] m_busy;
   logic       m_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int popcnt(input logic [7:0] v);
      int c = 0;
      for (int i = 0; i < 8; i++) if (v[i]) c++;
      return c;
   endfunction

   function automatic logic [2:0] lowest_free(input logic [7:0] b);
      logic [2:0] r = 3'd0;
      for (int i = 7; i >= 0; i--) if (!b[i]) r = 3'(i);
      return r;
   endfunction

   // One clock cycle: drive at negedge, check comb outputs, then registered state after posedge.
   task automatic step(input logic r, input logic rv, input logic [2:0] ri);
      comb_exp_t  ce;
      state_exp_t se;
      logic       g;
      logic       hit;
      @(negedge clk);
      req     = r;
      rel_v   = rv;
      rel_idx = ri;
      g          = r && (m_busy != 8'hFF);
      ce.grant   = g;
      ce.idx     = lowest_free(m_busy);
      ce.chk_idx = (m_busy != 8'hFF);
      q_comb.push_back(ce);
      hit = rv && m_busy[ri];
      if (g) m_busy[ce.idx] = 1'b1;
      if (hit) m_busy[ri] = 1'b0;
      if (rv && !hit) m_err = 1'b1;
      se.busy  = m_busy;
      se.cnt   = 4'(popcnt(m_busy));
      se.full  = (popcnt(m_busy) == 8);
      se.empty = (popcnt(m_busy) == 0);
      se.err   = m_err;
      q_state.push_back(se);
      #1;
      ce = q_comb.pop_front();
      check("grant", 64'(grant), 64'(ce.grant));
      if (ce.chk_idx) check("index", 64'(idx), 64'(ce.idx));
      @(posedge clk);
      #1;
      se = q_state.pop_front();
      check("busy", 64'(busy), 64'(se.busy));
      check("count", 64'(cnt), 64'(se.cnt));
      check("full", 64'(full), 64'(se.full));
      check("empty", 64'(empty), 64'(se.empty));
      check("error", 64'(err), 64'(se.err));
   endtask

   // Assert reset between edges with active inputs; deassert just after a posedge.
   task automatic apply_reset();
      #2;
      rst     = 1'b1;
      req     = 1'b1;
      rel_v   = 1'b1;
      rel_idx = 3'd0;
      #1;
      check("rst_busy", 64'(busy), 64'(8'h00));
      check("rst_count", 64'(cnt), 64'(4'd0));
      check("rst_full", 64'(full), 64'(1'b0));
      check("rst_empty", 64'(empty), 64'(1'b1));
      check("rst_error", 64'(err), 64'(1'b0));
      check("rst_grant", 64'(grant), 64'(1'b0));
      check("rst_index", 64'(idx), 64'(3'd0));
      @(posedge clk);
      #1;
      check("rst_hold_busy", 64'(busy), 64'(8'h00));
      rst    = 1'b0;
      req    = 1'b0;
      rel_v  = 1'b0;
      m_busy = 8'h00;
      m_err  = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      req     = 1'b0;
      rel_v   = 1'b0;
      rel_idx = 3'd0;
      m_busy  = 8'h00;
      m_err   = 1'b0;
      apply_reset();

      // Fill from empty: eight grants then a dropped request
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 3'd0);
      check("fill_full", 64'(full), 64'(1'b1));
      check("fill_count", 64'(cnt), 64'(4'd8));

      // Full with same-cycle release: no grant, slot 5 free next cycle
      step(1'b1, 1'b1, 3'd5);
      check("full_rel_busy", 64'(busy), 64'(8'hDF));
      step(1'b1, 1'b0, 3'd0);
      check("refill_busy", 64'(busy), 64'(8'hFF));

      // Double release of slot 3
      step(1'b0, 1'b1, 3'd3);
      step(1'b0, 1'b1, 3'd3);
      check("dbl_err", 64'(err), 64'(1'b1));
      check("dbl_busy", 64'(busy), 64'(8'hF7));
      step(1'b0, 1'b0, 3'd0);
      step(1'b1, 1'b0, 3'd0);
      check("err_sticky", 64'(err), 64'(1'b1));

      // Async reset mid-fill at count 4
      apply_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3'd0);
      check("mid_count", 64'(cnt), 64'(4'd4));
      apply_reset();
      step(1'b1, 1'b0, 3'd0);
      check("post_rst_busy", 64'(busy), 64'(8'h01));

      // Hole reuse
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0);
      step(1'b0, 1'b1, 3'd1);
      step(1'b1, 1'b0, 3'd0);
      check("hole_busy", 64'(busy), 64'(8'h0F));

      // Simultaneous grant and release while not full
      step(1'b0, 1'b1, 3'd3);
      step(1'b0, 1'b1, 3'd2);
      step(1'b1, 1'b1, 3'd0);
      check("sim_busy", 64'(busy), 64'(8'h06));
      check("sim_count", 64'(cnt), 64'(4'd2));

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
- REQ-001: The block SHALL have parameter NUM_SLOT, default 8, giving the number of trackable slots (power of two, 2..64).
- REQ-002: The block SHALL have parameter NUM_SLOT_LOG2, default 3, giving the width of slot indices (log2 of NUM_SLOT).
- REQ-003: The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004: The block SHALL have port reset_in, input, 1 bit: reset, asynchronous and active-high.
- REQ-005: The block SHALL have port alloc_request_in, input, 1 bit: a consumer requests one free slot this cycle.
- REQ-006: The block SHALL have port alloc_grant_out, output, 1 bit: the request is accepted this cycle.
- REQ-007: The block SHALL have port alloc_index_out, output, NUM_SLOT_LOG2 bits: the slot index granted, or the candidate index when no request is present.
- REQ-008: The block SHALL have port release_valid_in, input, 1 bit: a slot is returned this cycle.
- REQ-009: The block SHALL have port release_index_in, input, NUM_SLOT_LOG2 bits: the index of the slot being returned.
- REQ-010: The block SHALL have port busy_vector_out, output, NUM_SLOT bits: the registered occupancy bitmap, bit i = 1 when slot i is allocated.
- REQ-011: The block SHALL have port busy_count_out, output, NUM_SLOT_LOG2+1 bits: the registered number of allocated slots.
- REQ-012: The block SHALL have port full_out, output, 1 bit: registered; 1 when busy_count_out == NUM_SLOT.
- REQ-013: The block SHALL have port empty_out, output, 1 bit: registered; 1 when busy_count_out == 0.
- REQ-014: The block SHALL have port error_out, output, 1 bit: sticky protocol-error flag.

Function
- REQ-015: The candidate index SHALL be the lowest-numbered 0 bit of busy_vector_out, produced by an instance of find_first_one_index on the inverted bitmap, with MAX_OUTPUT_WIDTH = 32 and the output truncated to NUM_SLOT_LOG2 bits.
- REQ-016: alloc_grant_out and alloc_index_out SHALL be combinational from registered state and alloc_request_in; allocation latency is zero cycles, with the grant in the same cycle as the request.
- REQ-017: alloc_grant_out SHALL equal alloc_request_in AND NOT full_out; when full, no grant is given, the request is dropped (not queued), and the state is unchanged.
- REQ-018: On a grant, the bit at alloc_index_out SHALL be set on the next rising edge.
- REQ-019: On release_valid_in with the addressed bit at 1, that bit SHALL be cleared on the next rising edge.
- REQ-020: A simultaneous grant and valid release in the same cycle SHALL both take effect; busy_count_out is unchanged, with the set and the clear applied to their respective bits.
- REQ-021: A slot released in cycle N SHALL NOT be grantable in cycle N; it becomes a candidate from cycle N+1. Consequently, with full_out = 1, a same-cycle release does not enable a grant.
- REQ-022: busy_count_out SHALL be +1 on a grant only, -1 on a valid release only, and unchanged on both or neither; it never wraps past 0 or NUM_SLOT.
- REQ-023: full_out and empty_out SHALL be registered and updated in the same edge as busy_count_out, consistent with its next value.
- REQ-024: A release of a slot whose bit is already 0 SHALL have no effect on the bitmap or the count and SHALL set error_out on the next edge.
- REQ-025: A release_index_in >= NUM_SLOT (possible only when NUM_SLOT is not a power of two, which is disallowed) SHALL be treated as in REQ-024.
- REQ-026: error_out SHALL remain 1 until reset.
- REQ-027: busy_count_out SHALL always equal the population count of busy_vector_out; an implementation violating this is non-compliant.

Reset
- REQ-028: While reset_in = 1, the block SHALL hold busy_vector_out = 0, busy_count_out = 0, full_out = 0, empty_out = 1, error_out = 0, alloc_grant_out = 0 (inputs ignored), and alloc_index_out = 0.
- REQ-029: Reset asserted mid-operation SHALL clear all state immediately and asynchronously; pending grants and releases in that cycle are discarded.
- REQ-030: The first grant after reset_in deasserts SHALL be possible in the first clock cycle after deassertion.

Verification
- REQ-031: Fill from empty: alloc_request_in = 1 for 9 cycles -> grants at indices 0..7 in order, 9th cycle alloc_grant_out = 0, full_out = 1, busy_count_out = 8.
- REQ-032: Hole reuse: allocate 0..3, release 1, then request -> index 1 granted, busy_vector_out = 8'b0000_1111.
- REQ-033: Simultaneous full-case: full, release 5 plus request in the same cycle -> no grant that cycle, busy_vector_out = 8'b1101_1111, next cycle request grants 5.
- REQ-034: Simultaneous non-full: busy = 8'b0000_0011, release 0 plus request -> grant index 2, next busy = 8'b0000_0110, count stays 2.
- REQ-035: Double release: release 3 when bit 3 = 0 -> bitmap and count unchanged, error_out = 1 next cycle and held until reset.
- REQ-036: Async reset mid-fill: assert reset_in between clock edges with busy_count_out = 4 -> all outputs at reset values before the next edge; after deassertion the first request grants index 0.
